// File: rtl/aes_key_expand.sv
// AES-128 key schedule: loads a cipher key and streams round keys 0..ROUNDS over valid/ready.
// Define KEY_STORE_EN to keep every round key in a readable array (rd_idx_i -> rd_key_o).

module S_BOX (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Index 0 is the leftmost byte of the concatenation.
  localparam logic [0:255][7:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_o = TABLE[in_i];

endmodule

module aes_key_expand #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [127:0] key_in_i,
  input  logic         rk_ready_i,
  output logic         rk_valid_o,
  output logic [127:0] rk_out_o,
  output logic [3:0]   rk_idx_o,
  output logic         busy_o,
  output logic         done_o,
  input  logic [3:0]   rd_idx_i,
  output logic [127:0] rd_key_o
);

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS);

  typedef enum logic {IDLE, RUN} state_e;

  state_e       state_q;
  logic         rk_valid_q;
  logic [127:0] rk_out_q;
  logic [3:0]   rk_idx_q;
  logic         busy_q;
  logic         done_q;
  logic [7:0]   rcon_q;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w, sub_w, t_w;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] rk_d;
  logic [7:0]   rcon_d;
  logic         xfer, load, step;

  assign {w0, w1, w2, w3} = rk_out_q;
  assign rot_w = {w3[23:0], w3[31:24]};

  genvar g;
  for (g = 0; g < 4; g++) begin : g_sbox
    S_BOX u_sbox (
      .in_i  (rot_w[8*g +: 8]),
      .out_o (sub_w[8*g +: 8])
    );
  end

  assign t_w    = sub_w ^ {rcon_q, 24'h000000};
  assign n0     = w0 ^ t_w;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;
  assign rk_d   = {n0, n1, n2, n3};
  assign rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  assign xfer = rk_valid_q & rk_ready_i;
  assign load = (state_q == IDLE) & start_i;
  assign step = (state_q == RUN) & xfer & (rk_idx_q != LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rk_valid_q <= 1'b0;
      rk_out_q   <= '0;
      rk_idx_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rcon_q     <= 8'h01;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= RUN;
            rk_out_q   <= key_in_i;
            rk_idx_q   <= '0;
            rk_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            rcon_q     <= 8'h01;
          end
        end
        RUN: begin
          // Last key accepted: leave rk_out/rk_idx showing the final round key.
          if (xfer && rk_idx_q == LAST_IDX) begin
            state_q    <= IDLE;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            rcon_q     <= 8'h01;
          end else if (xfer) begin
            rk_out_q <= rk_d;
            rk_idx_q <= rk_idx_q + 4'd1;
            rcon_q   <= rcon_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rk_valid_o = rk_valid_q;
  assign rk_out_o   = rk_out_q;
  assign rk_idx_o   = rk_idx_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

`ifdef KEY_STORE_EN
  logic [127:0] store_q [0:ROUNDS];
  logic [127:0] rd_key_q;

  // Entries survive done so the cipher can replay them in reverse for decryption.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= ROUNDS; i++) store_q[i] <= '0;
      rd_key_q <= '0;
    end else begin
      if (load) store_q[0] <= key_in_i;
      else if (step) store_q[rk_idx_q + 4'd1] <= rk_d;
      rd_key_q <= (rd_idx_i <= LAST_IDX) ? store_q[rd_idx_i] : '0;
    end
  end

  assign rd_key_o = rd_key_q;
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx_i;
  assign rd_key_o      = '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand against an FIPS-197 style key schedule model.
// Build with KEY_STORE_EN defined to also exercise the round-key store.

module tb_aes_key_expand;

  localparam int ROUNDS = 10;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] keyIn;
  logic         rkReady;
  logic         rkValid;
  logic [127:0] rkOut;
  logic [3:0]   rkIdx;
  logic         busy;
  logic         done;
  logic [3:0]   rdIdx;
  logic [127:0] rdKey;

  int nPass = 0;
  int nTotal = 0;

  logic [7:0]   sboxRef [0:255];
  logic [127:0] refKeys [0:ROUNDS];
  logic [127:0] seenKeys [0:ROUNDS];

  aes_key_expand #(.ROUNDS(ROUNDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .key_in_i   (keyIn),
    .rk_ready_i (rkReady),
    .rk_valid_o (rkValid),
    .rk_out_o   (rkOut),
    .rk_idx_o   (rkIdx),
    .busy_o     (busy),
    .done_o     (done),
    .rd_idx_i   (rdIdx),
    .rd_key_o   (rdKey)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^8) arithmetic with the AES polynomial; the S-box is derived from it.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sboxRef[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWordRef(input logic [31:0] v);
    return {sboxRef[v[31:24]], sboxRef[v[23:16]], sboxRef[v[15:8]], sboxRef[v[7:0]]};
  endfunction

  // Word-by-word expansion of the 44-word schedule, grouped into round keys.
  task automatic modelExpand(input logic [127:0] key);
    logic [31:0] w [0:4*ROUNDS+3];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*ROUNDS+4; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = subWordRef({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= ROUNDS; r++) refKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Runs one expansion from IDLE; returns at the negedge where done should be visible.
  task automatic runExpansion(input logic [127:0] key, input int readyPct, input int injectAt,
                              input string name);
    int idx = 0;
    int cyc = 0;
    bit injected = 0;
    logic rdy;
    modelExpand(key);
    start = 1'b1;
    keyIn = key;
    rkReady = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    keyIn = {$urandom, $urandom, $urandom, $urandom};
    while (idx <= ROUNDS && cyc < 400) begin
      cyc++;
      nTotal++;
      if (rkValid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || rkIdx !== 4'(idx) ||
          rkOut !== refKeys[idx])
        $display("[TB] FAIL %s stream: got valid=%b busy=%b done=%b idx=%0d key=%h, expected valid=1 busy=1 done=0 idx=%0d key=%h",
                 name, rkValid, busy, done, rkIdx, rkOut, idx, refKeys[idx]);
      else nPass++;
      seenKeys[idx] = rkOut;
      start = 1'b0;
      if (!injected && idx == injectAt) begin
        start = 1'b1;
        keyIn = ~key;
        injected = 1;
      end
      rdy = ($urandom_range(0, 99) < readyPct);
      rkReady = rdy;
      @(negedge clk);
      if (rdy) idx++;
    end
    start = 1'b0;
    rkReady = 1'($urandom_range(0, 1));
    if (cyc >= 400) begin
      nTotal++;
      $display("[TB] FAIL %s timeout: reached idx %0d, expected %0d", name, idx, ROUNDS + 1);
    end
    nTotal++;
    if (rkValid !== 1'b0 || busy !== 1'b0 || done !== 1'b1 || rkIdx !== 4'(ROUNDS) ||
        rkOut !== refKeys[ROUNDS])
      $display("[TB] FAIL %s done: got valid=%b busy=%b done=%b idx=%0d key=%h, expected valid=0 busy=0 done=1 idx=%0d key=%h",
               name, rkValid, busy, done, rkIdx, rkOut, ROUNDS, refKeys[ROUNDS]);
    else nPass++;
    if (readyPct >= 100) begin
      nTotal++;
      if (cyc !== ROUNDS + 1)
        $display("[TB] FAIL %s valid cycles: got %0d, expected %0d", name, cyc, ROUNDS + 1);
      else nPass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    nTotal++;
    if (rkValid !== 1'b0 || rkOut !== '0 || rkIdx !== 4'd0 || busy !== 1'b0 || done !== 1'b0 ||
        rdKey !== '0)
      $display("[TB] FAIL reset: got valid=%b key=%h idx=%0d busy=%b done=%b rd=%h, expected all zero",
               rkValid, rkOut, rkIdx, busy, done, rdKey);
    else nPass++;
    rst = 1'b0;
    rkReady = 1'b1;
    repeat (3) @(negedge clk);
    nTotal++;
    if (rkValid !== 1'b0 || rkIdx !== 4'd0 || busy !== 1'b0 || done !== 1'b0)
      $display("[TB] FAIL idle ready: got valid=%b idx=%0d busy=%b done=%b, expected 0 0 0 0",
               rkValid, rkIdx, busy, done);
    else nPass++;
  endtask

  task automatic test_done_clears(input string name);
    @(negedge clk);
    nTotal++;
    if (done !== 1'b0 || rkValid !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL %s after done: got done=%b valid=%b busy=%b, expected 0 0 0",
               name, done, rkValid, busy);
    else nPass++;
  endtask

  task automatic test_fips();
    runExpansion(FIPS_KEY, 100, -1, "fips");
    nTotal++;
    if (seenKeys[0] !== FIPS_KEY || seenKeys[1] !== FIPS_RK1 || seenKeys[ROUNDS] !== FIPS_RK10)
      $display("[TB] FAIL fips vectors: got rk0=%h rk1=%h rk10=%h, expected %h %h %h",
               seenKeys[0], seenKeys[1], seenKeys[ROUNDS], FIPS_KEY, FIPS_RK1, FIPS_RK10);
    else nPass++;
    test_done_clears("fips");
  endtask

  task automatic test_key_store();
`ifdef KEY_STORE_EN
    for (int i = 0; i <= ROUNDS; i++) begin
      rdIdx = 4'(i);
      @(negedge clk);
      nTotal++;
      if (rdKey !== refKeys[i])
        $display("[TB] FAIL store rd%0d: got %h, expected %h", i, rdKey, refKeys[i]);
      else nPass++;
    end
    rdIdx = 4'd15;
    @(negedge clk);
    nTotal++;
    if (rdKey !== '0) $display("[TB] FAIL store rd15: got %h, expected 0", rdKey);
    else nPass++;
`else
    rdIdx = 4'd1;
    @(negedge clk);
    nTotal++;
    if (rdKey !== '0) $display("[TB] FAIL store disabled: got %h, expected 0", rdKey);
    else nPass++;
`endif
    rdIdx = 4'd0;
  endtask

  task automatic test_zero_key();
    runExpansion('0, 100, -1, "zero");
    nTotal++;
    if (seenKeys[1] !== ZERO_RK1)
      $display("[TB] FAIL zero rk1: got %h, expected %h", seenKeys[1], ZERO_RK1);
    else nPass++;
    test_done_clears("zero");
  endtask

  task automatic test_backpressure();
    logic [127:0] key;
    key = {$urandom, $urandom, $urandom, $urandom};
    runExpansion(key, 40, -1, "backpressure");
    test_done_clears("backpressure");
    runExpansion(key, 100, -1, "backpressure full");
    test_done_clears("backpressure full");
  endtask

  task automatic test_start_ignored();
    runExpansion({$urandom, $urandom, $urandom, $urandom}, 70, 4, "start ignored");
    test_done_clears("start ignored");
  endtask

  task automatic test_back_to_back();
    runExpansion({$urandom, $urandom, $urandom, $urandom}, 100, ROUNDS, "b2b first");
    runExpansion({$urandom, $urandom, $urandom, $urandom}, 60, -1, "b2b second");
    test_done_clears("b2b");
  endtask

  task automatic test_reset_abort();
    start = 1'b1;
    keyIn = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    start = 1'b0;
    rkReady = 1'b1;
    for (int c = 0; c < 30 && rkIdx !== 4'd6; c++) @(negedge clk);
    nTotal++;
    if (rkIdx !== 4'd6) $display("[TB] FAIL abort reach idx6: got %0d, expected 6", rkIdx);
    else nPass++;
    rst = 1'b1;
    #1;
    nTotal++;
    if (rkValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("[TB] FAIL abort async: got valid=%b busy=%b done=%b, expected 0 0 0",
               rkValid, busy, done);
    else nPass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nTotal++;
    if (rkValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("[TB] FAIL abort release: got valid=%b busy=%b done=%b, expected 0 0 0",
               rkValid, busy, done);
    else nPass++;
    runExpansion({$urandom, $urandom, $urandom, $urandom}, 100, -1, "restart");
    test_done_clears("restart");
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    keyIn = '0;
    rkReady = 1'b0;
    rdIdx = 4'd0;
    buildSbox();
    test_reset();
    test_fips();
    test_key_store();
    test_zero_key();
    test_backpressure();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
